scroll_tick_gen: RTL and testbench
==================================

// Module: scroll_tick_gen
// PURPOSE
//  Consumer end of the 2-bit difficulty code. Decodes difficulty_converted into a scroll
//  period and emits one-cycle scroll_tick pulses plus a wrapping beat counter.
//  Sits between the difficulty conversion stage and the arrow scroller / spawn logic.
//  Difficulty changes take effect only on tick boundaries, so the scroll never glitches.
// PARAMETERS
//  SLOW_DIV  50_000_000  clocks per tick for code 2'b11 (easy); must be >= 2
//  FAST_DIV  25_000_000  clocks per tick for code 2'b01 (hard); must be >= 2
//  DIV_W     26          width of the divider counter; must hold max(SLOW_DIV,FAST_DIV)-1
//  BEAT_W    8           width of beat_count
// PORTS
//  clk                  input   1       system clock, rising edge
//  rst                  input   1       asynchronous, active-high reset
//  difficulty_converted input   2       11=slow, 01=fast, 10=neutral/stop, 00=invalid
//  start                input   1       1-cycle pulse: begin scrolling
//  stop                 input   1       1-cycle pulse: abort to IDLE
//  pause                input   1       level: freeze divider while high
//  scroll_tick          output  1       registered 1-cycle pulse per scroll step
//  beat_count           output  BEAT_W  ticks since start, wraps 2^BEAT_W-1 -> 0
//  active_code          output  2       code currently in force (00 when IDLE)
//  running              output  1       1 in RUN or HOLD
//  code_err             output  1       registered 1-cycle pulse on invalid-code event
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, div_cnt=0, scroll_tick=0, beat_count=0,
//   active_code=00, running=0, code_err=0. Flops reset immediately; no clock needed.
//  States: IDLE, RUN, HOLD. Event priority per edge: stop > start > pause > tick.
//  Code decode: 11->SLOW_DIV, 01->FAST_DIV; 10 and 00 are not runnable.
//  IDLE: divider cleared, no ticks.
//   start=1 with runnable code -> RUN. Latch active_code. div_cnt=0, beat_count=0.
//   start=1 with code 00 -> stay IDLE, code_err=1 for one cycle.
//   start=1 with code 10 -> ignored silently.
//  RUN: div_cnt increments each cycle. At the edge where div_cnt==DIV-1:
//   - scroll_tick<=1; div_cnt<=0; beat_count<=beat_count+1 (modulo 2^BEAT_W).
//   - Resample difficulty_converted. If 11/01: adopt it as active_code for the next period.
//     If 10: go to IDLE after this tick. If 00: keep old code and pulse code_err.
//   Latency: start sampled at edge k -> first scroll_tick high in the cycle after edge k+DIV.
//   Subsequent ticks follow every DIV cycles.
//   Code changes between boundaries have no effect on the current period.
//  RUN with pause=1 -> HOLD. Takes effect the same edge: div_cnt frozen, no tick,
//   even if div_cnt==DIV-1.
//  HOLD: all counters frozen, scroll_tick=0. pause=0 -> RUN, resuming from the frozen div_cnt.
//  stop=1 in RUN/HOLD -> IDLE. div_cnt=0, active_code=00, scroll_tick=0 next cycle.
//   beat_count is held for score readout.
//  start while RUN/HOLD: restarts, same as from IDLE.
//  scroll_tick is never high for 2 consecutive cycles (DIV>=2).
//  running = (state != IDLE).
// TESTING (bench uses SLOW_DIV=8, FAST_DIV=4, BEAT_W=3)
//  1. code=11, start @cycle 0 -> scroll_tick high at cycles 8,16,24; beat_count 1,2,3; active_code=11.
//  2. Run at 11; switch code to 01 mid-period -> current period stays 8.
//     Following ticks are 4 apart; active_code changes to 01 exactly at the tick.
//  3. pause high for 5 cycles, starting with div_cnt=6 -> next tick delayed by exactly 5 cycles.
//     pause held through the terminal count -> no tick until released.
//  4. start with code=00 -> stays IDLE, single code_err pulse, no ticks.
//     Code 00 at a RUN boundary -> code_err pulse, period unchanged.
//  5. 9 ticks at BEAT_W=3 -> beat_count wraps 7->0. Code 10 at a boundary -> that tick fires, then IDLE.
//  6. Assert rst mid-RUN, between clock edges -> all outputs zero immediately.
//     stop and start in the same cycle -> IDLE wins.

Source files
------------

// File: rtl/scroll_tick_gen.sv
// scroll_tick_gen: decodes the 2-bit difficulty code into a scroll period and
// emits one-cycle scroll_tick pulses plus a wrapping beat counter. Difficulty
// changes are only adopted on tick boundaries so the scroll never glitches.
module scroll_tick_gen #(
  parameter int SLOW_DIV = 50_000_000,
  parameter int FAST_DIV = 25_000_000,
  parameter int DIV_W    = 26,
  parameter int BEAT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        difficulty_converted,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic              scroll_tick,
  output logic [BEAT_W-1:0] beat_count,
  output logic [1:0]        active_code,
  output logic              running,
  output logic              code_err
);

  localparam logic [1:0] CODE_SLOW = 2'b11;
  localparam logic [1:0] CODE_FAST = 2'b01;
  localparam logic [1:0] CODE_STOP = 2'b10;
  localparam logic [1:0] CODE_IDLE = 2'b00;

  localparam logic [DIV_W-1:0] SLOW_MAX = DIV_W'(SLOW_DIV - 1);
  localparam logic [DIV_W-1:0] FAST_MAX = DIV_W'(FAST_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t              r_state, w_state_next;
  logic [DIV_W-1:0]    r_div_cnt, w_div_next;
  logic [BEAT_W-1:0]   r_beat, w_beat_next;
  logic [1:0]          r_code, w_code_next;
  logic                r_tick, w_tick_next;
  logic                r_err, w_err_next;

  logic                w_runnable;
  logic [DIV_W-1:0]    w_div_max;

  // 11 and 01 are the only codes that carry a scroll period
  assign w_runnable = (difficulty_converted == CODE_SLOW) ||
                      (difficulty_converted == CODE_FAST);
  // terminal count of the period currently in force
  assign w_div_max  = (r_code == CODE_FAST) ? FAST_MAX : SLOW_MAX;

  // state and counter registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_div_cnt <= '0;
      r_beat    <= '0;
      r_code    <= CODE_IDLE;
      r_tick    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_div_cnt <= w_div_next;
      r_beat    <= w_beat_next;
      r_code    <= w_code_next;
      r_tick    <= w_tick_next;
      r_err     <= w_err_next;
    end
  end

  // next-state logic; event priority is stop > start > pause > tick
  always_comb begin
    w_state_next = r_state;
    w_div_next   = r_div_cnt;
    w_beat_next  = r_beat;
    w_code_next  = r_code;
    w_tick_next  = 1'b0;
    w_err_next   = 1'b0;

    if (stop) begin
      // abort: beat_count is kept so the score can still be read out
      w_state_next = ST_IDLE;
      w_div_next   = '0;
      w_code_next  = CODE_IDLE;
    end else if (start && w_runnable) begin
      w_state_next = ST_RUN;
      w_code_next  = difficulty_converted;
      w_div_next   = '0;
      w_beat_next  = '0;
    end else begin
      // a start with a non-runnable code is otherwise ignored; 00 is flagged
      if (start && (difficulty_converted == CODE_IDLE)) begin
        w_err_next = 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          w_div_next = '0;
        end
        ST_RUN, ST_HOLD: begin
          if (pause) begin
            // frozen on the same edge pause is seen, even at terminal count
            w_state_next = ST_HOLD;
          end else begin
            // releasing pause counts this edge, so the delay equals pause cycles
            w_state_next = ST_RUN;
            if (r_div_cnt == w_div_max) begin
              w_tick_next = 1'b1;
              w_div_next  = '0;
              w_beat_next = r_beat + BEAT_W'(1);
              case (difficulty_converted)
                CODE_SLOW, CODE_FAST: w_code_next = difficulty_converted;
                CODE_STOP: begin
                  w_state_next = ST_IDLE;
                  w_code_next  = CODE_IDLE;
                end
                default: w_err_next = 1'b1;
              endcase
            end else begin
              w_div_next = r_div_cnt + DIV_W'(1);
            end
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_div_next   = '0;
          w_code_next  = CODE_IDLE;
        end
      endcase
    end
  end

  assign scroll_tick = r_tick;
  assign beat_count  = r_beat;
  assign active_code = r_code;
  assign running     = (r_state != ST_IDLE);
  assign code_err    = r_err;

endmodule

// File: tb/tb_scroll_tick_gen.sv
// Scoreboard bench for scroll_tick_gen with SLOW_DIV=8, FAST_DIV=4, BEAT_W=3.
module tb_scroll_tick_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] difficulty_converted = 2'b00;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       scroll_tick;
  logic [2:0] beat_count;
  logic [1:0] active_code;
  logic       running;
  logic       code_err;

  typedef struct {
    int         edge_n;
    logic [2:0] beat;
    logic [1:0] code;
  } tick_t;

  tick_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    e = 0;

  scroll_tick_gen #(
    .SLOW_DIV(8),
    .FAST_DIV(4),
    .DIV_W(4),
    .BEAT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .difficulty_converted(difficulty_converted),
    .start(start),
    .stop(stop),
    .pause(pause),
    .scroll_tick(scroll_tick),
    .beat_count(beat_count),
    .active_code(active_code),
    .running(running),
    .code_err(code_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({scroll_tick, beat_count, active_code, running, code_err} !== 8'b0) begin
      bad++;
      $display("FAIL reset_outputs: actual tick=%b beat=%0d code=%b run=%b err=%b required all zero",
               scroll_tick, beat_count, active_code, running, code_err);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    total++;
    if (running !== 1'b0 || scroll_tick !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: actual run=%b tick=%b required 0 0", running, scroll_tick);
    end
  endtask

  task automatic test_slow_run();
    int    k;
    tick_t t;
    difficulty_converted = 2'b11;
    start = 1'b1;
    step();
    start = 1'b0;
    k = e;
    total++;
    if (active_code !== 2'b11 || running !== 1'b1) begin
      bad++;
      $display("FAIL start_latch: actual code=%b run=%b required 11 1", active_code, running);
    end
    exp_q.push_back('{k + 8, 3'd1, 2'b11});
    exp_q.push_back('{k + 16, 3'd2, 2'b11});
    exp_q.push_back('{k + 24, 3'd3, 2'b11});
    for (int i = 0; i < 26; i++) begin
      step();
      if (scroll_tick === 1'b1) begin
        total++;
        $display("tick edge=%0d beat=%0d code=%b", e - k, beat_count, active_code);
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL slow_unexpected_tick: edge=%0d actual=1 required=0", e - k);
        end else begin
          t = exp_q.pop_front();
          if (e !== t.edge_n || beat_count !== t.beat || active_code !== t.code) begin
            bad++;
            $display("FAIL slow_tick: actual edge=%0d beat=%0d code=%b required edge=%0d beat=%0d code=%b",
                     e - k, beat_count, active_code, t.edge_n - k, t.beat, t.code);
          end
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL slow_missing: actual pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    total++;
    if (running !== 1'b0 || active_code !== 2'b00 || beat_count !== 3'd3) begin
      bad++;
      $display("FAIL stop_hold_beat: actual run=%b code=%b beat=%0d required 0 00 3",
               running, active_code, beat_count);
    end
  endtask

  task automatic test_code_switch();
    int    k;
    tick_t t;
    difficulty_converted = 2'b11;
    start = 1'b1;
    step();
    start = 1'b0;
    k = e;
    exp_q.push_back('{k + 8, 3'd1, 2'b01});
    exp_q.push_back('{k + 12, 3'd2, 2'b01});
    exp_q.push_back('{k + 16, 3'd3, 2'b01});
    for (int i = 0; i < 17; i++) begin
      if (e + 1 == k + 3) difficulty_converted = 2'b01;
      step();
      if (e == k + 7) begin
        total++;
        if (active_code !== 2'b11) begin
          bad++;
          $display("FAIL switch_early: actual code=%b required 11", active_code);
        end
      end
      if (scroll_tick === 1'b1) begin
        total++;
        $display("tick edge=%0d beat=%0d code=%b", e - k, beat_count, active_code);
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL switch_unexpected_tick: edge=%0d actual=1 required=0", e - k);
        end else begin
          t = exp_q.pop_front();
          if (e !== t.edge_n || beat_count !== t.beat || active_code !== t.code) begin
            bad++;
            $display("FAIL switch_tick: actual edge=%0d beat=%0d code=%b required edge=%0d beat=%0d code=%b",
                     e - k, beat_count, active_code, t.edge_n - k, t.beat, t.code);
          end
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL switch_missing: actual pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_pause();
    int    k;
    tick_t t;
    difficulty_converted = 2'b11;
    start = 1'b1;
    step();
    start = 1'b0;
    k = e;
    exp_q.push_back('{k + 13, 3'd1, 2'b11});
    exp_q.push_back('{k + 25, 3'd2, 2'b11});
    for (int i = 0; i < 27; i++) begin
      pause = ((e + 1 >= k + 7) && (e + 1 <= k + 11)) ||
              ((e + 1 >= k + 21) && (e + 1 <= k + 24));
      step();
      if (e == k + 9) begin
        total++;
        if (running !== 1'b1 || scroll_tick !== 1'b0) begin
          bad++;
          $display("FAIL hold_running: actual run=%b tick=%b required 1 0", running, scroll_tick);
        end
      end
      if (scroll_tick === 1'b1) begin
        total++;
        $display("tick edge=%0d beat=%0d code=%b", e - k, beat_count, active_code);
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pause_unexpected_tick: edge=%0d actual=1 required=0", e - k);
        end else begin
          t = exp_q.pop_front();
          if (e !== t.edge_n || beat_count !== t.beat || active_code !== t.code) begin
            bad++;
            $display("FAIL pause_tick: actual edge=%0d beat=%0d code=%b required edge=%0d beat=%0d code=%b",
                     e - k, beat_count, active_code, t.edge_n - k, t.beat, t.code);
          end
        end
      end
    end
    pause = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pause_missing: actual pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_invalid_code();
    int    k;
    tick_t t;
    difficulty_converted = 2'b00;
    start = 1'b1;
    step();
    start = 1'b0;
    k = e;
    total++;
    if (code_err !== 1'b1 || running !== 1'b0) begin
      bad++;
      $display("FAIL bad_start: actual err=%b run=%b required 1 0", code_err, running);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (e == k + 1) begin
        total++;
        if (code_err !== 1'b0) begin
          bad++;
          $display("FAIL bad_start_pulse: actual err=%b required 0", code_err);
        end
      end
      if (scroll_tick === 1'b1) begin
        total++;
        bad++;
        $display("FAIL idle_tick: edge=%0d actual=1 required=0", e - k);
      end
    end
    difficulty_converted = 2'b11;
    start = 1'b1;
    step();
    start = 1'b0;
    k = e;
    exp_q.push_back('{k + 8, 3'd1, 2'b11});
    exp_q.push_back('{k + 16, 3'd2, 2'b11});
    for (int i = 0; i < 17; i++) begin
      if (e + 1 == k + 5) difficulty_converted = 2'b00;
      step();
      if (e == k + 8 || e == k + 9) begin
        total++;
        if (code_err !== (e == k + 8)) begin
          bad++;
          $display("FAIL boundary_err: edge=%0d actual err=%b required %b", e - k, code_err, (e == k + 8));
        end
      end
      if (scroll_tick === 1'b1) begin
        total++;
        $display("tick edge=%0d beat=%0d code=%b", e - k, beat_count, active_code);
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL err_unexpected_tick: edge=%0d actual=1 required=0", e - k);
        end else begin
          t = exp_q.pop_front();
          if (e !== t.edge_n || beat_count !== t.beat || active_code !== t.code) begin
            bad++;
            $display("FAIL err_tick: actual edge=%0d beat=%0d code=%b required edge=%0d beat=%0d code=%b",
                     e - k, beat_count, active_code, t.edge_n - k, t.beat, t.code);
          end
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL err_missing: actual pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_wrap_and_neutral();
    int    k;
    tick_t t;
    difficulty_converted = 2'b01;
    start = 1'b1;
    step();
    start = 1'b0;
    k = e;
    for (int n = 1; n <= 9; n++) begin
      exp_q.push_back('{k + 4 * n, 3'(n % 8), (n == 9) ? 2'b00 : 2'b01});
    end
    for (int i = 0; i < 46; i++) begin
      if (e + 1 == k + 34) difficulty_converted = 2'b10;
      step();
      if (scroll_tick === 1'b1) begin
        total++;
        $display("tick edge=%0d beat=%0d code=%b", e - k, beat_count, active_code);
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL wrap_unexpected_tick: edge=%0d actual=1 required=0", e - k);
        end else begin
          t = exp_q.pop_front();
          if (e !== t.edge_n || beat_count !== t.beat || active_code !== t.code) begin
            bad++;
            $display("FAIL wrap_tick: actual edge=%0d beat=%0d code=%b required edge=%0d beat=%0d code=%b",
                     e - k, beat_count, active_code, t.edge_n - k, t.beat, t.code);
          end
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL wrap_missing: actual pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    total++;
    if (running !== 1'b0 || beat_count !== 3'd1) begin
      bad++;
      $display("FAIL neutral_idle: actual run=%b beat=%0d required 0 1", running, beat_count);
    end
  endtask

  task automatic test_reset_and_stop_start();
    int    k;
    tick_t t;
    difficulty_converted = 2'b11;
    start = 1'b1;
    step();
    start = 1'b0;
    k = e;
    exp_q.push_back('{k + 8, 3'd1, 2'b11});
    for (int i = 0; i < 8; i++) begin
      step();
      if (scroll_tick === 1'b1) begin
        total++;
        $display("tick edge=%0d beat=%0d code=%b", e - k, beat_count, active_code);
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rst_unexpected_tick: edge=%0d actual=1 required=0", e - k);
        end else begin
          t = exp_q.pop_front();
          if (e !== t.edge_n || beat_count !== t.beat || active_code !== t.code) begin
            bad++;
            $display("FAIL rst_tick: actual edge=%0d beat=%0d code=%b required edge=%0d beat=%0d code=%b",
                     e - k, beat_count, active_code, t.edge_n - k, t.beat, t.code);
          end
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rst_missing: actual pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({scroll_tick, beat_count, active_code, running, code_err} !== 8'b0) begin
      bad++;
      $display("FAIL async_reset: actual tick=%b beat=%0d code=%b run=%b err=%b required all zero",
               scroll_tick, beat_count, active_code, running, code_err);
    end
    #1;
    rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    stop = 1'b1;
    start = 1'b1;
    step();
    stop = 1'b0;
    start = 1'b0;
    k = e;
    total++;
    if (running !== 1'b0 || active_code !== 2'b00) begin
      bad++;
      $display("FAIL stop_beats_start: actual run=%b code=%b required 0 00", running, active_code);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (scroll_tick === 1'b1 || running === 1'b1) begin
        total++;
        bad++;
        $display("FAIL post_stop_activity: edge=%0d actual tick=%b run=%b required 0 0",
                 e - k, scroll_tick, running);
      end
    end
  endtask

  initial begin
    test_reset();
    test_slow_run();
    test_code_switch();
    test_pause();
    test_invalid_code();
    test_wrap_and_neutral();
    test_reset_and_stop_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
